// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter among NUM_REQ byte sources. Every source owns a
// one-deep slot that it fills with a single-cycle tick. Pending slots are
// served round-robin: the chosen byte is latched onto o_tx_data, o_tx_start
// pulses for one cycle, and the arbiter then waits for the UART's done tick
// (or gives up after TIMEOUT_CLKS cycles) before picking the next slot.
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   i_req_tick       per-source write strobe (one cycle)
//   i_req_data       source k byte at [k*DATA_BITS +: DATA_BITS]
//   i_tx_done_tick   UART o_tx_done_tick
//   o_tx_start       UART i_tx_start, one-cycle pulse
//   o_tx_data        UART i_tx_data, held until the next grant
//   o_slot_full      slot k holds an unsent byte
//   o_sent_tick      pulse: byte from source k completed
//   o_overflow_tick  pulse: tick k dropped because slot k was full
//   o_timeout_tick   pulse: wait for done was aborted
//   o_busy           FSM is not idle
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_BITS    = 8,
    parameter int TIMEOUT_CLKS = 20000,
    parameter int TO_BIT       = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           i_req_tick,
    input  logic [NUM_REQ*DATA_BITS-1:0] i_req_data,
    input  logic                         i_tx_done_tick,
    output logic                         o_tx_start,
    output logic [DATA_BITS-1:0]         o_tx_data,
    output logic [NUM_REQ-1:0]           o_slot_full,
    output logic [NUM_REQ-1:0]           o_sent_tick,
    output logic [NUM_REQ-1:0]           o_overflow_tick,
    output logic                         o_timeout_tick,
    output logic                         o_busy
);

    localparam int PTR_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t                 state_q,      state_d;
    logic [DATA_BITS-1:0]   slot_data_q   [NUM_REQ];
    logic [DATA_BITS-1:0]   slot_data_d   [NUM_REQ];
    logic [NUM_REQ-1:0]     slot_valid_q, slot_valid_d;
    logic [PTR_BITS-1:0]    rr_q,         rr_d;
    logic [PTR_BITS-1:0]    grant_q,      grant_d;
    logic [TO_BIT-1:0]      cnt_q,        cnt_d;
    logic                   tx_start_q,   tx_start_d;
    logic [DATA_BITS-1:0]   tx_data_q,    tx_data_d;
    logic [NUM_REQ-1:0]     sent_q,       sent_d;
    logic [NUM_REQ-1:0]     ovf_q,        ovf_d;
    logic                   timeout_q,    timeout_d;
    logic                   busy_q,       busy_d;

    // Round-robin search result
    logic                   found;
    logic [PTR_BITS-1:0]    pick;
    logic                   grant_now;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case/if logic can leave a value unassigned (no latches).
        found = 1'b0;
        pick  = '0;

        // First valid slot strictly after the rr pointer, wrapping modulo NUM_REQ.
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && slot_valid_q[(int'(rr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                pick  = PTR_BITS'((int'(rr_q) + i) % NUM_REQ);
            end
        end

        grant_now = (state_q == S_IDLE) && found;

        state_d      = state_q;
        slot_data_d  = slot_data_q;
        slot_valid_d = slot_valid_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        sent_d       = '0;
        ovf_d        = '0;
        timeout_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    tx_data_d          = slot_data_q[pick];
                    slot_valid_d[pick] = 1'b0;
                    rr_d               = pick;
                    grant_d            = pick;
                    tx_start_d         = 1'b1;
                    state_d            = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done is tested first so it wins over the final timeout cycle.
                if (i_tx_done_tick) begin
                    sent_d[grant_q] = 1'b1;
                    state_d         = S_IDLE;
                end else if (cnt_q == TO_BIT'(TIMEOUT_CLKS - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TO_BIT'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Slot capture runs after the grant so a tick on the slot being
        // granted this cycle re-fills it instead of overflowing.
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_req_tick[k]) begin
                if (!slot_valid_q[k] || (grant_now && int'(pick) == k)) begin
                    slot_data_d[k]  = i_req_data[k*DATA_BITS +: DATA_BITS];
                    slot_valid_d[k] = 1'b1;
                end else begin
                    ovf_d[k] = 1'b1;
                end
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            // NOTE: slot storage is small, so it is reset along with the
            // control state; nothing stale can reach o_tx_data after reset.
            for (int k = 0; k < NUM_REQ; k++) slot_data_q[k] <= '0;
            slot_valid_q <= '0;
            rr_q         <= PTR_BITS'(NUM_REQ - 1);
            grant_q      <= '0;
            cnt_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            sent_q       <= '0;
            ovf_q        <= '0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            slot_data_q  <= slot_data_d;
            slot_valid_q <= slot_valid_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            sent_q       <= sent_d;
            ovf_q        <= ovf_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign o_tx_start      = tx_start_q;
    assign o_tx_data       = tx_data_q;
    assign o_slot_full     = slot_valid_q;
    assign o_sent_tick     = sent_q;
    assign o_overflow_tick = ovf_q;
    assign o_timeout_tick  = timeout_q;
    assign o_busy          = busy_q;

endmodule
